// File: rtl/threshold_frame_trigger.sv
// Hysteresis frame trigger: baseline-subtracts a multi-lane sample stream, opens frames on a rising
// threshold hit with pre/post acquisition, caps frame length, and emits framed AXIS beats.
module threshold_frame_trigger_lane #(
  parameter int SW = 16
) (
  input  logic [SW-1:0] smp_i,
  input  logic [SW-1:0] bl_i,
  input  logic [SW-1:0] s1_i,
  input  logic [SW-1:0] rise_i,
  input  logic [SW-1:0] fall_i,
  output logic [SW-1:0] sub_o,
  output logic          clip_o,
  output logic          hit_o,
  output logic          quiet_o
);
  logic [SW:0] diff;
  assign diff    = {smp_i[SW-1], smp_i} - {bl_i[SW-1], bl_i};
  // top two bits disagree exactly when the difference left the SW-bit range
  assign clip_o  = diff[SW] ^ diff[SW-1];
  assign sub_o   = clip_o ? {diff[SW], {(SW-1){~diff[SW]}}} : diff[SW-1:0];
  assign hit_o   = $signed(s1_i) >= $signed(rise_i);
  assign quiet_o = $signed(s1_i) <  $signed(fall_i);
endmodule

module threshold_frame_trigger #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int SAMPLES_PER_CLK  = 8,
  parameter int TIMESTAMP_WIDTH  = 48,
  parameter int MAX_PRE_LENGTH   = 4,
  parameter int MAX_POST_LENGTH  = 4,
  parameter int MAX_FRAME_LENGTH = 256
) (
  input  logic                                      ACLK,
  input  logic                                      ARESETN,
  input  logic                                      SET_CONFIG,
  input  logic                                      STOP,
  input  logic [SAMPLES_PER_CLK*SAMPLE_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                                      S_AXIS_TVALID,
  input  logic [TIMESTAMP_WIDTH-1:0]                TIMESTAMP,
  input  logic [SAMPLE_WIDTH-1:0]                   RISING_EDGE_THRESHOLD,
  input  logic [SAMPLE_WIDTH-1:0]                   FALLING_EDGE_THRESHOLD,
  input  logic [SAMPLE_WIDTH-1:0]                   BASELINE,
  input  logic [$clog2(MAX_PRE_LENGTH+1)-1:0]       PRE_LENGTH,
  input  logic [$clog2(MAX_POST_LENGTH+1)-1:0]      POST_LENGTH,
  output logic [SAMPLES_PER_CLK*SAMPLE_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [TIMESTAMP_WIDTH+1:0]                M_AXIS_TUSER,
  output logic                                      M_AXIS_TVALID,
  output logic                                      M_AXIS_TLAST,
  output logic [31:0]                               FRAME_COUNT,
  output logic [15:0]                               SPLIT_COUNT
);
  localparam int SW = SAMPLE_WIDTH;
  localparam int NL = SAMPLES_PER_CLK;
  localparam int DW = SW*NL;
  localparam int TW = TIMESTAMP_WIDTH;
  localparam int PW = $clog2(MAX_PRE_LENGTH+1);
  localparam int QW = $clog2(MAX_POST_LENGTH+1);
  localparam int CW = $clog2(MAX_PRE_LENGTH+MAX_POST_LENGTH+1);
  localparam int BW = $clog2(MAX_FRAME_LENGTH+1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_POST} state_e;

  logic [SW-1:0] rise_q, fall_q, bl_q;
  logic [PW-1:0] pre_q;
  logic [QW-1:0] post_q;

  logic [NL-1:0][SW-1:0] sub, s1_dat_q, s2_dat_q, d_dat;
  logic [NL-1:0]         lane_clip, lane_hit, lane_quiet;
  logic                  s1_clip_q, s2_clip_q, s2_hit_q, s2_quiet_q, d_clip;
  logic [TW-1:0]         s1_ts_q, s2_ts_q, d_ts;

  logic [MAX_PRE_LENGTH-1:0][DW-1:0] dl_dat_q;
  logic [MAX_PRE_LENGTH-1:0]         dl_clip_q;
  logic [MAX_PRE_LENGTH-1:0][TW-1:0] dl_ts_q;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, tail_len;
  logic [BW-1:0] bc_q;
  logic          gate, fend, split, last, first;

  logic [DW-1:0]   tdata_q;
  logic [TW+1:0]   tuser_q;
  logic            tvalid_q, tlast_q;
  logic [31:0]     fc_q;
  logic [15:0]     sc_q;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    threshold_frame_trigger_lane #(.SW(SW)) u_lane (
      .smp_i  (S_AXIS_TDATA[i*SW +: SW]),
      .bl_i   (bl_q),
      .s1_i   (s1_dat_q[i]),
      .rise_i (rise_q),
      .fall_i (fall_q),
      .sub_o  (sub[i]),
      .clip_o (lane_clip[i]),
      .hit_o  (lane_hit[i]),
      .quiet_o(lane_quiet[i])
    );
  end

  assign tail_len = CW'(pre_q) + CW'(post_q);

  // gate decided on stage2 beat m pairs with data beat m-PRE from the delay line
  always_comb begin
    d_dat  = s2_dat_q;
    d_clip = s2_clip_q;
    d_ts   = s2_ts_q;
    for (int k = 0; k < MAX_PRE_LENGTH; k++) begin
      if (pre_q == PW'(k+1)) begin
        d_dat  = dl_dat_q[k];
        d_clip = dl_clip_q[k];
        d_ts   = dl_ts_q[k];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (SET_CONFIG) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (S_AXIS_TVALID) begin
      case (state_q)
        S_IDLE:   if (s2_hit_q && !STOP) state_d = S_ACTIVE;
        S_ACTIVE: if (s2_quiet_q) begin
                    if (tail_len == '0) state_d = S_IDLE;
                    else begin
                      state_d = S_POST;
                      cnt_d   = tail_len;
                    end
                  end
        S_POST:   if (s2_hit_q)              state_d = S_ACTIVE;
                  else if (cnt_q == CW'(1))  state_d = S_IDLE;
                  else                       cnt_d   = cnt_q - CW'(1);
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    gate = 1'b0;
    fend = 1'b0;
    case (state_q)
      S_IDLE:   gate = s2_hit_q & ~STOP;
      S_ACTIVE: begin gate = 1'b1; fend = s2_quiet_q & (tail_len == '0); end
      S_POST:   begin gate = 1'b1; fend = ~s2_hit_q & (cnt_q == CW'(1)); end
      default:  gate = 1'b0;
    endcase
  end

  // beat counter at zero marks the first beat, both for a fresh trigger and after a split
  assign first = (bc_q == '0);
  assign split = (bc_q == BW'(MAX_FRAME_LENGTH-1));
  assign last  = fend | split;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rise_q <= SW'(1024);  fall_q <= SW'(1024);  bl_q <= '0;
      pre_q  <= PW'(1);     post_q <= QW'(1);
      s1_dat_q <= '0; s1_clip_q <= 1'b0; s1_ts_q <= '0;
      s2_dat_q <= '0; s2_clip_q <= 1'b0; s2_ts_q <= '0; s2_hit_q <= 1'b0; s2_quiet_q <= 1'b0;
      dl_dat_q <= '0; dl_clip_q <= '0; dl_ts_q <= '0;
      tdata_q <= '0; tuser_q <= '0; tvalid_q <= 1'b0; tlast_q <= 1'b0;
      bc_q <= '0; fc_q <= '0; sc_q <= '0;
    end else if (SET_CONFIG) begin
      rise_q <= RISING_EDGE_THRESHOLD;
      fall_q <= FALLING_EDGE_THRESHOLD;
      bl_q   <= BASELINE;
      pre_q  <= (PRE_LENGTH  > PW'(MAX_PRE_LENGTH))  ? PW'(MAX_PRE_LENGTH)  : PRE_LENGTH;
      post_q <= (POST_LENGTH > QW'(MAX_POST_LENGTH)) ? QW'(MAX_POST_LENGTH) : POST_LENGTH;
      s1_dat_q <= '0; s1_clip_q <= 1'b0; s1_ts_q <= '0;
      s2_dat_q <= '0; s2_clip_q <= 1'b0; s2_ts_q <= '0; s2_hit_q <= 1'b0; s2_quiet_q <= 1'b0;
      dl_dat_q <= '0; dl_clip_q <= '0; dl_ts_q <= '0;
      tdata_q <= '0; tuser_q <= '0; tvalid_q <= 1'b0; tlast_q <= 1'b0;
      bc_q <= '0;
    end else if (S_AXIS_TVALID) begin
      s1_dat_q   <= sub;
      s1_clip_q  <= |lane_clip;
      s1_ts_q    <= TIMESTAMP;
      s2_dat_q   <= s1_dat_q;
      s2_clip_q  <= s1_clip_q;
      s2_ts_q    <= s1_ts_q;
      s2_hit_q   <= |lane_hit;
      s2_quiet_q <= &lane_quiet;
      dl_dat_q[0]  <= s2_dat_q;
      dl_clip_q[0] <= s2_clip_q;
      dl_ts_q[0]   <= s2_ts_q;
      for (int k = 1; k < MAX_PRE_LENGTH; k++) begin
        dl_dat_q[k]  <= dl_dat_q[k-1];
        dl_clip_q[k] <= dl_clip_q[k-1];
        dl_ts_q[k]   <= dl_ts_q[k-1];
      end
      tdata_q  <= d_dat;
      tuser_q  <= {d_ts, d_clip, first};
      tvalid_q <= gate;
      tlast_q  <= gate & last;
      if (gate) begin
        bc_q <= last ? '0 : bc_q + BW'(1);
        if (last)                    fc_q <= fc_q + 32'd1;
        if (split && sc_q != 16'hFFFF) sc_q <= sc_q + 16'd1;
      end
    end else begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end
  end

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TUSER  = tuser_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign FRAME_COUNT   = fc_q;
  assign SPLIT_COUNT   = sc_q;
endmodule

// File: tb/tb_threshold_frame_trigger.sv
// Random + directed bench for threshold_frame_trigger against a beat-history reference model.
module tb_threshold_frame_trigger;
  localparam int SW = 16, NL = 8, DW = SW*NL, TW = 48, MAXF = 16, MAXPRE = 4, MAXPOST = 4;

  logic ACLK = 1'b0;
  logic ARESETN, SET_CONFIG, STOP, tvalid;
  logic [DW-1:0] tdata;
  logic [TW-1:0] ts;
  logic [SW-1:0] rise, fall, bl;
  logic [2:0]    pre_len, post_len;
  logic [DW-1:0] m_tdata;
  logic [TW+1:0] m_tuser;
  logic          m_tvalid, m_tlast;
  logic [31:0]   frame_count;
  logic [15:0]   split_count;

  always #5 ACLK = ~ACLK;

  threshold_frame_trigger #(
    .SAMPLE_WIDTH(SW), .SAMPLES_PER_CLK(NL), .TIMESTAMP_WIDTH(TW),
    .MAX_PRE_LENGTH(MAXPRE), .MAX_POST_LENGTH(MAXPOST), .MAX_FRAME_LENGTH(MAXF)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .SET_CONFIG(SET_CONFIG), .STOP(STOP),
    .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid), .TIMESTAMP(ts),
    .RISING_EDGE_THRESHOLD(rise), .FALLING_EDGE_THRESHOLD(fall), .BASELINE(bl),
    .PRE_LENGTH(pre_len), .POST_LENGTH(post_len),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TUSER(m_tuser), .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TLAST(m_tlast), .FRAME_COUNT(frame_count), .SPLIT_COUNT(split_count)
  );

  typedef struct {
    logic [DW-1:0] dat;
    bit            clip;
    logic [TW-1:0] ts;
    bit            hit;
    bit            quiet;
  } beat_t;

  beat_t         hist[$];          // accepted beats since the last flush, index = beat number
  int            m_rise, m_fall, m_bl, m_pre, m_post;
  bit            in_event;
  int            tail_left, flen, scnt;
  logic [31:0]   fcnt;
  logic          e_valid, e_last;
  logic [DW-1:0] e_dat;
  logic [TW+1:0] e_user;
  int            n_cmp, n_bad, cyc, burst_left, cur_bl, cur_rise;

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rise = 1024; m_fall = 1024; m_bl = 0; m_pre = 1; m_post = 1;
    hist.delete();
    in_event = 0; tail_left = -1; flen = 0; fcnt = '0; scnt = 0;
    e_valid = 0; e_last = 0; e_dat = '0; e_user = '0;
    cur_bl = 0; cur_rise = 1024;
  endtask

  // what the block should present after the coming clock edge, given the inputs now applied
  task automatic model_edge();
    beat_t b, bd;
    int n, m, d;
    bit hit, quiet, gate, fin, first, split;
    if (SET_CONFIG) begin
      m_rise = int'($signed(rise)); m_fall = int'($signed(fall)); m_bl = int'($signed(bl));
      m_pre  = (pre_len  > 3'(MAXPRE))  ? MAXPRE  : int'(pre_len);
      m_post = (post_len > 3'(MAXPOST)) ? MAXPOST : int'(post_len);
      hist.delete();
      in_event = 0; tail_left = -1; flen = 0;
      e_valid = 0; e_last = 0; e_dat = '0; e_user = '0;
      return;
    end
    if (!tvalid) begin
      e_valid = 0; e_last = 0;
      return;
    end
    b.dat = '0; b.clip = 0; b.ts = ts; b.hit = 0; b.quiet = 1;
    for (int i = 0; i < NL; i++) begin
      int v;
      v = int'($signed(tdata[i*SW +: SW])) - m_bl;
      if (v > 32767) begin v = 32767; b.clip = 1; end
      else if (v < -32768) begin v = -32768; b.clip = 1; end
      b.dat[i*SW +: SW] = v[SW-1:0];
      if (v >= m_rise) b.hit = 1;
      if (v >= m_fall) b.quiet = 0;
    end
    hist.push_back(b);
    n = hist.size() - 1;
    m = n - 2;                     // beat the trigger decision is about
    hit = (m >= 0) ? hist[m].hit : 1'b0;
    quiet = (m >= 0) ? hist[m].quiet : 1'b0;
    gate = 0; fin = 0;
    if (!in_event) begin
      if (hit && !STOP) begin in_event = 1; tail_left = -1; gate = 1; end
    end else begin
      gate = 1;
      if (tail_left < 0) begin
        if (quiet) begin
          if (m_pre + m_post == 0) fin = 1;
          else tail_left = m_pre + m_post;
        end
      end else if (hit) tail_left = -1;
      else if (tail_left == 1) fin = 1;
      else tail_left--;
    end
    e_valid = gate; e_last = 0;
    if (gate) begin
      d = m - m_pre;
      bd.dat = '0; bd.clip = 0; bd.ts = '0; bd.hit = 0; bd.quiet = 0;
      if (d >= 0) bd = hist[d];
      first = (flen == 0);
      flen++;
      split = (flen == MAXF);
      e_last = fin || split;
      e_dat  = bd.dat;
      e_user = {bd.ts, bd.clip, first};
      if (e_last) begin
        fcnt = fcnt + 32'd1;
        flen = 0;
        if (split && scnt < 65535) scnt++;
      end
      if (fin) in_event = 0;
    end
  endtask

  task automatic check_out();
    chk("tvalid", DW'(m_tvalid), DW'(e_valid));
    chk("tlast", DW'(m_tlast), DW'(e_last));
    chk("frame_count", DW'(frame_count), DW'(fcnt));
    chk("split_count", DW'(split_count), DW'(scnt));
    if (e_valid) begin
      chk("tdata", m_tdata, e_dat);
      chk("tuser", DW'(m_tuser), DW'(e_user));
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_tvalid"}, DW'(m_tvalid), '0);
    chk({tag, "_tlast"}, DW'(m_tlast), '0);
    chk({tag, "_tdata"}, m_tdata, '0);
    chk({tag, "_tuser"}, DW'(m_tuser), '0);
    chk({tag, "_frame_count"}, DW'(frame_count), '0);
    chk({tag, "_split_count"}, DW'(split_count), '0);
  endtask

  // inputs are applied at a falling edge; the model predicts the next rising edge
  task automatic tick();
    ts = TW'(cyc) + TW'(48'h1000);
    model_edge();
    @(negedge ACLK);
    cyc++;
    check_out();
  endtask

  function automatic logic [DW-1:0] flat(int base, int lane, int val);
    logic [DW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*SW +: SW] = (i == lane) ? 16'(val) : 16'(base);
    return r;
  endfunction

  task automatic drive(bit v, logic [DW-1:0] d);
    tvalid = v; tdata = d;
    tick();
  endtask

  task automatic do_config(int b, int r, int f, int p, int q);
    SET_CONFIG = 1; bl = 16'(b); rise = 16'(r); fall = 16'(f);
    pre_len = 3'(p); post_len = 3'(q);
    tvalid = 1; tdata = flat(b, 0, b + r + 100);   // this beat is discarded by the flush
    tick();
    SET_CONFIG = 0;
    cur_bl = b; cur_rise = r;
  endtask

  task automatic rand_beat();
    logic [DW-1:0] d;
    for (int i = 0; i < NL; i++) d[i*SW +: SW] = 16'(cur_bl + int'($urandom_range(0, 200)) - 100);
    if (burst_left > 0) begin
      int ln;
      ln = int'($urandom_range(0, NL-1));
      d[ln*SW +: SW] = 16'(cur_bl + cur_rise + int'($urandom_range(0, 600)));
    end
    if ($urandom_range(0, 99) < 3) begin
      int ln;
      ln = int'($urandom_range(0, NL-1));
      d[ln*SW +: SW] = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
    end
    tvalid = ($urandom_range(0, 99) < 75);
    tdata = d;
    if (tvalid && burst_left > 0) burst_left--;
    tick();
  endtask

  initial begin
    ARESETN = 0; SET_CONFIG = 0; STOP = 0; tvalid = 0; tdata = '0; ts = '0;
    rise = 16'd1024; fall = 16'd1024; bl = '0; pre_len = 3'd1; post_len = 3'd1;
    n_cmp = 0; n_bad = 0; cyc = 0; burst_left = 0;
    model_reset();
    repeat (3) @(negedge ACLK);
    check_zero("reset");
    ARESETN = 1;

    // single hit, pre=2 post=1
    do_config(100, 1024, 1024, 2, 1);
    for (int b = 0; b < 24; b++) drive(1, flat(100, (b == 10) ? 3 : -1, 1200));
    // second hit while the tail is running
    do_config(100, 1024, 1024, 2, 1);
    for (int b = 0; b < 26; b++) drive(1, flat(100, (b == 10 || b == 12) ? 3 : -1, 1200));
    // same event with TVALID toggling every cycle
    do_config(100, 1024, 1024, 2, 1);
    for (int b = 0; b < 48; b++) drive(b % 2 == 0, flat(100, (b == 20) ? 3 : -1, 1200));
    // saturation both ways, with a hit so the beats are emitted
    do_config(100, 1024, 1024, 1, 1);
    for (int b = 0; b < 10; b++) drive(1, flat(100, (b == 3) ? 0 : -1, -32768) | ((b == 3) ? flat(0, 1, 2000) & ~flat(0, -1, 0) : '0));
    do_config(-100, 1024, 1024, 0, 2);
    for (int b = 0; b < 10; b++) drive(1, flat(-100, (b == 3) ? 0 : -1, 32767));
    // long event split by the frame cap, no pre/post
    do_config(0, 1024, 1024, 0, 0);
    for (int b = 0; b < 50; b++) drive(1, flat(0, (b < 40) ? 5 : -1, 1500));
    // flush mid-frame, then STOP blocks a trigger
    do_config(0, 1024, 1024, 2, 1);
    for (int b = 0; b < 8; b++) drive(1, flat(0, 2, 1500));
    do_config(0, 1024, 1024, 7, 7);
    STOP = 1;
    for (int b = 0; b < 12; b++) drive(1, flat(0, (b == 4) ? 6 : -1, 1500));
    STOP = 0;
    for (int b = 0; b < 12; b++) drive(1, flat(0, -1, 0));

    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        ARESETN = 0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge ACLK);
        cyc++;
        ARESETN = 1;
      end
      if ($urandom_range(0, 99) < 3) STOP = ~STOP;
      if (burst_left == 0 && $urandom_range(0, 99) < 6) burst_left = int'($urandom_range(1, 40));
      if ($urandom_range(0, 199) < 2)
        do_config(int'($urandom_range(0, 400)) - 200, int'($urandom_range(200, 1500)),
                  int'($urandom_range(150, 1500)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      else
        rand_beat();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
